aoc2_range_parser: RTL and testbench

- Upstream stage of the Day-2 invalid-ID datapath.
- Consumes the puzzle input as an ASCII byte stream of comma-separated ranges ("11-22,95-115\n").
- Emits one binary (lo, hi) pair per range, plus per-bound digit counts, to the downstream range-sum stage, which uses the digit-count and prefix-table blocks.
- Single-entry registered output with valid/ready backpressure; flags malformed input.

---
 rtl/aoc2_range_parser_pkg.sv | 33 +++
 rtl/aoc2_range_parser_if.sv | 25 ++
 rtl/aoc2_range_parser_dec_acc.sv | 30 +++
 rtl/aoc2_range_parser.sv | 113 +++++++++++
 tb/tb_aoc2_range_parser.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/aoc2_range_parser_pkg.sv
// aoc2_range_parser_pkg: shared constants, parser states and decimal helpers for the Day-2 datapath
package aoc2_range_parser_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int MAX_DIGITS = 19;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [1:0] {S_LO, S_HI, S_ERR} state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_DASH  = 8'h2d;
    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_SP    = 8'h20;

    function automatic logic [DATA_WIDTH-1:0] pow10(input int n);
        logic [DATA_WIDTH-1:0] p;
        p = 1;
        for (int i = 0; i < n; i++) p = (p << 3) + (p << 1);
        return p;
    endfunction

    // Significant digits; zero counts as one digit, saturates at 15.
    function automatic logic [3:0] num_digits(input logic [DATA_WIDTH-1:0] v);
        logic [4:0] c;
        c = 5'd1;
        for (int i = 1; i <= MAX_DIGITS; i++) if (v >= pow10(i)) c = c + 5'd1;
        return (c > 5'd15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/aoc2_range_parser_if.sv
// aoc2_range_parser_if: byte-stream input and range-output handshakes of the range parser
interface aoc2_range_parser_if #(parameter int DATA_WIDTH = 64);

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  rng_valid;
    logic [DATA_WIDTH-1:0] rng_lo;
    logic [DATA_WIDTH-1:0] rng_hi;
    logic [3:0]            rng_lo_digs;
    logic [3:0]            rng_hi_digs;
    logic                  rng_ready;

    modport master (
        output in_valid, in_data, in_last, rng_ready,
        input  in_ready, rng_valid, rng_lo, rng_hi, rng_lo_digs, rng_hi_digs
    );

    modport slave (
        input  in_valid, in_data, in_last, rng_ready,
        output in_ready, rng_valid, rng_lo, rng_hi, rng_lo_digs, rng_hi_digs
    );

endinterface

// File: rtl/aoc2_range_parser_dec_acc.sv
// aoc2_range_parser_dec_acc: decimal accumulator with digit counter, shared by lo and hi phases
module aoc2_range_parser_dec_acc #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DIGITS = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [3:0]            digit,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] nxt,
    output logic [4:0]            dcnt,
    output logic                  full
);

    assign nxt  = (acc << 3) + (acc << 1) + DATA_WIDTH'(digit);
    assign full = dcnt == 5'(MAX_DIGITS);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc  <= '0;
            dcnt <= '0;
        end else if (push) begin
            acc  <= nxt;
            dcnt <= dcnt + 5'd1;
        end
    end

endmodule

// File: rtl/aoc2_range_parser.sv
// aoc2_range_parser: parses "lo-hi," ASCII ranges into binary bound pairs with digit counts
module aoc2_range_parser
    import aoc2_range_parser_pkg::*;
#(
    parameter int DATA_WIDTH = aoc2_range_parser_pkg::DATA_WIDTH,
    parameter int MAX_DIGITS = aoc2_range_parser_pkg::MAX_DIGITS,
    parameter int CNT_WIDTH  = aoc2_range_parser_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    aoc2_range_parser_if.slave   bus,
    output logic [CNT_WIDTH-1:0] rng_count,
    output logic                 done,
    output logic                 err
);

    state_t                state, nstate;
    logic [DATA_WIDTH-1:0] acc, nxt, lo_q, hi_val;
    logic [3:0]            lo_digs_q;
    logic [4:0]            dcnt;
    logic                  full, push, clr, latch_lo, load, last_ok, end_pend;
    logic                  fire, retire, is_dig, is_term, is_sep;
    logic [7:0]            b;

    aoc2_range_parser_dec_acc #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .digit(b[3:0]),
        .acc(acc), .nxt(nxt), .dcnt(dcnt), .full(full)
    );

    assign b            = bus.in_data;
    assign fire         = bus.in_valid && bus.in_ready;
    assign retire       = bus.rng_valid && bus.rng_ready;
    assign is_dig       = b >= CH_0 && b <= CH_9;
    assign is_term      = b == CH_COMMA || b == CH_LF || b == CH_CR;
    assign is_sep       = is_term || b == CH_SP;
    assign hi_val       = is_dig ? nxt : acc;
    assign err          = state == S_ERR;
    assign bus.in_ready = err ? 1'b1 : !done && (!bus.rng_valid || bus.rng_ready);

    always_comb begin
        nstate   = state;
        push     = 1'b0;
        clr      = 1'b0;
        latch_lo = 1'b0;
        load     = 1'b0;
        last_ok  = 1'b0;
        if (fire) begin
            case (state)
                S_LO: begin
                    if (bus.in_last) begin
                        if (is_sep && dcnt == 0) last_ok = 1'b1;
                        else nstate = S_ERR;
                    end else if (is_dig) begin
                        if (full) nstate = S_ERR;
                        else push = 1'b1;
                    end else if (b == CH_DASH && dcnt != 0) begin
                        latch_lo = 1'b1;
                        clr      = 1'b1;
                        nstate   = S_HI;
                    end else if (!(is_sep && dcnt == 0)) nstate = S_ERR;
                end
                S_HI: begin
                    // A digit carrying in_last closes the range with itself included.
                    if (is_dig && full) nstate = S_ERR;
                    else if (is_dig && !bus.in_last) push = 1'b1;
                    else if (is_dig || (is_term && dcnt != 0)) begin
                        if (lo_q > hi_val) nstate = S_ERR;
                        else begin
                            load    = 1'b1;
                            clr     = 1'b1;
                            last_ok = bus.in_last;
                            nstate  = S_LO;
                        end
                    end else nstate = S_ERR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_LO;
            lo_q            <= '0;
            lo_digs_q       <= '0;
            bus.rng_valid   <= 1'b0;
            bus.rng_lo      <= '0;
            bus.rng_hi      <= '0;
            bus.rng_lo_digs <= '0;
            bus.rng_hi_digs <= '0;
            rng_count       <= '0;
            end_pend        <= 1'b0;
            done            <= 1'b0;
        end else begin
            state         <= nstate;
            rng_count     <= rng_count + CNT_WIDTH'(retire);
            end_pend      <= end_pend | last_ok;
            done          <= done | (end_pend && !err && (!bus.rng_valid || bus.rng_ready));
            bus.rng_valid <= (nstate == S_ERR) ? 1'b0 : load ? 1'b1 : retire ? 1'b0 : bus.rng_valid;
            if (latch_lo) begin
                lo_q      <= acc;
                lo_digs_q <= num_digits(acc);
            end
            if (load) begin
                bus.rng_lo      <= lo_q;
                bus.rng_hi      <= hi_val;
                bus.rng_lo_digs <= lo_digs_q;
                bus.rng_hi_digs <= num_digits(hi_val);
            end
        end
    end

endmodule

// File: tb/tb_aoc2_range_parser.sv
// tb_aoc2_range_parser: directed streams with a scoreboard queue checked by an output monitor
module tb_aoc2_range_parser;

    typedef struct packed {
        logic [63:0] lo;
        logic [63:0] hi;
        logic [3:0]  ld;
        logic [3:0]  hd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rng_count;
    logic        done, err;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          stalls = 0;

    aoc2_range_parser_if #(.DATA_WIDTH(64)) bif();

    aoc2_range_parser dut (
        .clk(clk), .rst(rst), .bus(bif), .rng_count(rng_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the range output retires one expected entry.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && bif.rng_valid && bif.rng_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_range: got lo=%0d hi=%0d expected none", bif.rng_lo, bif.rng_hi);
            end else begin
                e = q.pop_front();
                check("rng_lo", bif.rng_lo, e.lo);
                check("rng_hi", bif.rng_hi, e.hi);
                check("rng_lo_digs", 64'(bif.rng_lo_digs), 64'(e.ld));
                check("rng_hi_digs", 64'(bif.rng_hi_digs), 64'(e.hd));
            end
        end
    end

    task automatic send_byte(input logic [7:0] c, input logic last);
        int n = 0;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = c;
        bif.in_last  = last;
        #1;
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            stalls++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bif.rng_ready = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = 8'h00;
        bif.in_last   = 1'b0;
        bif.rng_ready = 1'b0;
        idle(3);
        check("reset_rng_valid", 64'(bif.rng_valid), 0);
        check("reset_rng_lo", bif.rng_lo, 0);
        check("reset_rng_count", 64'(rng_count), 0);
        check("reset_done", 64'(done), 0);
        check("reset_err", 64'(err), 0);
        rst = 1'b0;
        idle(1);
        check("reset_in_ready", 64'(bif.in_ready), 1);

        bif.rng_ready = 1'b1;
        q.push_back('{64'd11, 64'd22, 4'd2, 4'd2});
        q.push_back('{64'd95, 64'd115, 4'd2, 4'd3});
        send_str("11-22,95-115\n", 1'b1);
        idle(3);
        check("t1_count", 64'(rng_count), 2);
        check("t1_done", 64'(done), 1);
        check("t1_err", 64'(err), 0);
        check("t1_in_ready_after_done", 64'(bif.in_ready), 0);

        do_reset();
        q.push_back('{64'd1, 64'd9, 4'd1, 4'd1});
        send_str("1-9", 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(bif.rng_valid), 1);
            check("t2_hold_lo", bif.rng_lo, 1);
            check("t2_hold_hi", bif.rng_hi, 9);
            check("t2_hold_in_ready", 64'(bif.in_ready), 0);
            check("t2_hold_done", 64'(done), 0);
            idle(1);
        end
        bif.rng_ready = 1'b1;
        idle(1);
        check("t2_done", 64'(done), 1);
        check("t2_valid_cleared", 64'(bif.rng_valid), 0);
        check("t2_count", 64'(rng_count), 1);

        do_reset();
        bif.rng_ready = 1'b1;
        stalls = 0;
        q.push_back('{64'd998, 64'd1012, 4'd3, 4'd4});
        q.push_back('{64'd1188511880, 64'd1188511890, 4'd10, 4'd10});
        send_str("998-1012,1188511880-1188511890,", 1'b0);
        idle(2);
        check("t3_no_stalls", 64'(stalls), 0);
        check("t3_count", 64'(rng_count), 2);
        check("t3_err", 64'(err), 0);
        check("t3_done", 64'(done), 0);

        do_reset();
        bif.rng_ready = 1'b1;
        send_str("50-40,", 1'b0);
        idle(1);
        check("t4_err", 64'(err), 1);
        check("t4_drain_ready", 64'(bif.in_ready), 1);
        send_str("1-2,\n", 1'b1);
        idle(3);
        check("t4_err_sticky", 64'(err), 1);
        check("t4_done", 64'(done), 0);
        check("t4_count", 64'(rng_count), 0);
        check("t4_valid", 64'(bif.rng_valid), 0);

        do_reset();
        send_str("1234567890123456789", 1'b0);
        idle(1);
        check("t5_19_digits_ok", 64'(err), 0);
        send_str("0-1", 1'b0);
        idle(1);
        check("t5_20th_digit_err", 64'(err), 1);
        do_reset();
        send_str("1--2", 1'b0);
        idle(1);
        check("t5_double_dash_err", 64'(err), 1);
        do_reset();
        check("t5_reset_clears_err", 64'(err), 0);
        send_str("1-x", 1'b0);
        idle(1);
        check("t5_bad_char_err", 64'(err), 1);

        do_reset();
        send_str("5-7,", 1'b0);
        idle(1);
        check("t6_held_valid", 64'(bif.rng_valid), 1);
        check("t6_held_lo", bif.rng_lo, 5);
        check("t6_held_hi", bif.rng_hi, 7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_rst_valid", 64'(bif.rng_valid), 0);
        check("t6_rst_count", 64'(rng_count), 0);
        bif.rng_ready = 1'b1;
        q.push_back('{64'd3, 64'd4, 4'd1, 4'd1});
        send_str("3-4\n", 1'b1);
        idle(3);
        check("t6_count", 64'(rng_count), 1);
        check("t6_done", 64'(done), 1);

        check("scoreboard_empty", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
